// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the host command channel, the ALU drive/return lines and the result channel.
// The master modport is the host-plus-ALU side. The slave modport is the issuer.
interface alu_cmd_issuer_if #(parameter int AW = 2);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_a;
  logic [7:0]    cmd_b;
  logic [3:0]    cmd_sel;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_sel;
  logic [7:0]    alu_out;
  logic          alu_cout;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic          res_cout;
  logic          res_err;
  logic [AW:0]   fifo_count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_cout, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_cout,
           res_err, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_cout, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_cout,
           res_err, fifo_count
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers host ALU commands, drives the combinational ALU from registered operands,
// and returns each qualified result on a valid/ready channel, strictly in order.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_issuer_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;

  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_sel;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_cout;
  logic          res_err;

  logic          push;
  logic          pop;
  logic [19:0]   head;
  logic [9:0]    qualified;

  // Divide-by-zero is overridden to all-ones, and carry is only meaningful for add.
  function automatic logic [9:0] qualify(input logic [3:0] sel, input logic [7:0] b,
                                         input logic [7:0] out, input logic cout);
    if (sel == 4'd3 && b == 8'd0)
      return {1'b1, 1'b0, 8'hFF};
    return {1'b0, (sel == 4'd0) ? cout : 1'b0, out};
  endfunction

  assign bus.cmd_ready  = (count != FULL);
  assign bus.fifo_count = count;
  assign bus.alu_a      = alu_a;
  assign bus.alu_b      = alu_b;
  assign bus.alu_sel    = alu_sel;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = res_data;
  assign bus.res_cout   = res_cout;
  assign bus.res_err    = res_err;

  assign push      = bus.cmd_valid && (count != FULL);
  assign pop       = (count != '0) &&
                     ((state == IDLE) || (state == HOLD && bus.res_ready));
  assign head      = mem[rd_ptr];
  assign qualified = qualify(alu_sel, alu_b, bus.alu_out, bus.alu_cout);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {alu_a, alu_b, alu_sel} <= head;
            state <= EXEC;
          end
        end
        // ALU inputs have been stable for a full cycle; capture the result here.
        EXEC: begin
          res_valid <= 1'b1;
          res_err   <= qualified[9];
          res_cout  <= qualified[8];
          res_data  <= qualified[7:0];
          state     <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              {alu_a, alu_b, alu_sel} <= head;
              state <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed and random bench for alu_cmd_issuer with an in-order result scoreboard.
module tb_alu_cmd_issuer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.AW(2)) bus();

  alu_cmd_issuer #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  // Reference ALU. Carry is forced high for every opcode except add.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s);
    logic [15:0] p;
    case (s)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b1, a - b};
      4'd2: begin p = a * b; return {1'b1, p[7:0]}; end
      4'd3: return {1'b1, (b == 8'd0) ? 8'h00 : a / b};
      4'd4: return {1'b1, a << 1};
      4'd5: return {1'b1, a >> 1};
      4'd6: return {1'b1, a[6:0], a[7]};
      4'd7: return {1'b1, a[0], a[7:1]};
      4'd8: return {1'b1, a & b};
      4'd9: return {1'b1, a | b};
      4'd10: return {1'b1, a ^ b};
      default: return {1'b1, ~a};
    endcase
  endfunction

  always_comb {bus.alu_cout, bus.alu_out} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

  function automatic logic [9:0] expected(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
    logic [8:0] r;
    r = alu_fn(a, b, s);
    if (s == 4'd3 && b == 8'd0) return {1'b1, 1'b0, 8'hFF};
    return {1'b0, (s == 4'd0) ? r[8] : 1'b0, r[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard: in-order results, plus stability while stalled.
  logic       stall = 1'b0;
  logic [9:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (!bus.res_valid || {bus.res_err, bus.res_cout, bus.res_data} !== held) begin
          errors++;
          $display("FAIL stall_stable got %0b_%0h want 1_%0h", bus.res_valid,
                   {bus.res_err, bus.res_cout, bus.res_data}, held);
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got %0h want none", bus.res_data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({bus.res_err, bus.res_cout, bus.res_data} !== e) begin
            errors++;
            $display("FAIL scoreboard got %0h want %0h", {bus.res_err, bus.res_cout, bus.res_data}, e);
          end
        end
      end
      stall = bus.res_valid && !bus.res_ready;
      held  = {bus.res_err, bus.res_cout, bus.res_data};
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back(expected(bus.cmd_a, bus.cmd_b, bus.cmd_sel));
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    bit ok = 1'b0;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_sel = s; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
    end
    if (!ok) check("push_timeout", 0, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [7:0] d, input logic c,
                            input logic e);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        seen = 1'b1;
        check({name, "_data"}, bus.res_data, d);
        check({name, "_cout"}, bus.res_cout, c);
        check({name, "_err"}, bus.res_err, e);
      end
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  logic [7:0] seq [5] = '{8'h14, 8'h14, 8'h05, 8'h14, 8'h05};
  logic [3:0] sels [5] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7};
  bit done = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
    bus.res_ready = 1'b0;

    @(negedge clk);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_count", bus.fifo_count, 0);
    check("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
    check("rst_res", {bus.res_err, bus.res_cout, bus.res_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Latency: accepted at edge T, valid after T+2.
    bus.res_ready = 1'b1;
    push(8'h0A, 8'h02, 4'd0);
    @(negedge clk); check("lat_t0", bus.res_valid, 0);
    @(negedge clk); check("lat_t1", bus.res_valid, 0);
    @(negedge clk); check("lat_t2", bus.res_valid, 1);
    check("add_data", bus.res_data, 8'h0C);
    check("add_cout", bus.res_cout, 0);
    check("add_err", bus.res_err, 0);
    @(posedge clk); #1;

    push(8'hF6, 8'h0A, 4'd0);  expect_res("carry", 8'h00, 1'b1, 1'b0);
    push(8'hF6, 8'h0A, 4'd1);  expect_res("sub", 8'hEC, 1'b0, 1'b0);
    push(8'h0A, 8'h00, 4'd3);  expect_res("div0", 8'hFF, 1'b0, 1'b1);
    push(8'h0A, 8'h02, 4'd3);  expect_res("div", 8'h05, 1'b0, 1'b0);

    // Back-pressure: fill to 1 issued + 4 buffered, then drain.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h0A, 8'h02, sels[i]);
    @(negedge clk);
    check("full_ready", bus.cmd_ready, 0);
    check("full_count", bus.fifo_count, 4);
    check("full_head", bus.res_data, 8'h14);
    repeat (3) @(negedge clk);
    check("stall_data", bus.res_data, 8'h14);
    @(posedge clk); #1 bus.res_ready = 1'b1;
    begin
      int n = 0;
      int last = 0;
      for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
        @(negedge clk);
        if (bus.res_valid) begin
          check("drain_data", bus.res_data, seq[n]);
          if (n > 0) check("drain_spacing", cyc - last, 2);
          last = cyc;
          n++;
        end
      end
      check("drain_count", n, 5);
    end
    @(posedge clk); #1;

    // Reset while EXEC with 3 buffered.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(i + 1), 8'h01, 4'd0);
    bus.res_ready = 1'b1;
    @(posedge clk); #1 bus.res_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_count", bus.fifo_count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_count", bus.fifo_count, 0);
    check("mid_rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
    check("mid_rst_ready", bus.cmd_ready, 1);
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    begin
      int stale = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.res_valid) stale++;
      end
      check("post_rst_stale", stale, 0);
    end
    @(posedge clk); #1;
    push(8'h33, 8'h11, 4'd1);  expect_res("post_rst", 8'h22, 1'b0, 1'b0);

    // Random traffic with random back-pressure, checked by the scoreboard.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [7:0] ra, rb;
          ra = 8'($urandom);
          rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
          push(ra, rb, 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.res_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("rand_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("rand_count", bus.fifo_count, 0);
    check("rand_idle_valid", bus.res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
